ram_port_arb: RTL and testbench

RAM_PORT_ARB -- requirements
Module: ram_port_arb

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/ram_port_arb.sv | 92 +++++++++
 tb/tb_ram_port_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Request struct widths match the arbiter's default ADDR_WIDTH/DATA_WIDTH.
package ram_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int REQ_ADDR_W = 15;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_BE_W   = REQ_DATA_W / 8;

  typedef logic port_idx_t;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  we;
    logic [REQ_BE_W-1:0]   be;
    logic [REQ_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: round-robin when RAM_PORT_ARB_RR_EN is defined,
// otherwise fixed priority with port 1 winning every conflict.
module rr_arb2
  import ram_arb_pkg::*;
(
`ifdef RAM_PORT_ARB_RR_EN
  input  logic                 clk,
  input  logic                 rst_n,
`endif
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 ptr_upd
);

  assign ptr_upd = |req;

`ifdef RAM_PORT_ARB_RR_EN
  port_idx_t ptr_q;

  // ptr_q holds the last-granted port; a conflict goes to the other one
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr_q == 1'b0) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (ptr_upd) begin
      ptr_q <= gnt[1];
    end
  end
`else
  always_comb begin
    gnt = req;
    if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ram_port_arb.sv
// Two-port front end for a single-port RAM: same-cycle grant, one-cycle response.
// Define RAM_PORT_ARB_RR_EN for round-robin arbitration (default: port 1 priority).
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  logic [NUM_PORTS-1:0] gnt;
  logic                 ptr_upd;
  ram_req_t             req0, req1, sel;
  logic                 pend_q;
  port_idx_t            idx_q;

  rr_arb2 u_arb (
`ifdef RAM_PORT_ARB_RR_EN
    .clk     (clk),
    .rst_n   (rst_n),
`endif
    .req     ({p1_req_i, p0_req_i}),
    .gnt     (gnt),
    .ptr_upd (ptr_upd)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];
  assign ram_en_o = |gnt;

  always_comb begin
    req0 = '{addr: REQ_ADDR_W'(p0_addr_i), we: p0_we_i,
             be: REQ_BE_W'(p0_be_i), wdata: REQ_DATA_W'(p0_wdata_i)};
    req1 = '{addr: REQ_ADDR_W'(p1_addr_i), we: p1_we_i,
             be: REQ_BE_W'(p1_be_i), wdata: REQ_DATA_W'(p1_wdata_i)};
    sel  = '0;
    if (gnt[1]) begin
      sel = req1;
    end else if (gnt[0]) begin
      sel = req0;
    end
  end

  assign ram_addr_o  = ADDR_WIDTH'(sel.addr);
  assign ram_we_o    = sel.we;
  assign ram_be_o    = (DATA_WIDTH/8)'(sel.be);
  assign ram_wdata_o = DATA_WIDTH'(sel.wdata);

  // Grants keep flowing during reset, but their responses must never surface
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      idx_q  <= 1'b0;
    end else begin
      pend_q <= ptr_upd;
      idx_q  <= gnt[1];
    end
  end

  assign p0_rvalid_o = rst_n & pend_q & (idx_q == 1'b0);
  assign p1_rvalid_o = rst_n & pend_q & (idx_q == 1'b1);
  assign p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_port_arb.sv
// Self-checking bench for ram_port_arb: directed scenarios then randomized traffic
// checked against a queue-based reference model (honours RAM_PORT_ARB_RR_EN).
module tb_ram_port_arb;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_i, p0_gnt_o, p0_we_i, p0_rvalid_o;
  logic [AW-1:0] p0_addr_i;
  logic [BW-1:0] p0_be_i;
  logic [DW-1:0] p0_wdata_i, p0_rdata_o;
  logic          p1_req_i, p1_gnt_o, p1_we_i, p1_rvalid_o;
  logic [AW-1:0] p1_addr_i;
  logic [BW-1:0] p1_be_i;
  logic [DW-1:0] p1_wdata_i, p1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: last-granted port and the responses owed next cycle
  int last_port = 0;
  int resp_q[$];

  ram_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_req_i    (p0_req_i),
    .p0_gnt_o    (p0_gnt_o),
    .p0_addr_i   (p0_addr_i),
    .p0_we_i     (p0_we_i),
    .p0_be_i     (p0_be_i),
    .p0_wdata_i  (p0_wdata_i),
    .p0_rvalid_o (p0_rvalid_o),
    .p0_rdata_o  (p0_rdata_o),
    .p1_req_i    (p1_req_i),
    .p1_gnt_o    (p1_gnt_o),
    .p1_addr_i   (p1_addr_i),
    .p1_we_i     (p1_we_i),
    .p1_be_i     (p1_be_i),
    .p1_wdata_i  (p1_wdata_i),
    .p1_rvalid_o (p1_rvalid_o),
    .p1_rdata_o  (p1_rdata_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, check 1ns later, then advance the model
  task automatic applyStimulus(
    input  logic rn,
    input  logic r0, input logic [AW-1:0] a0, input logic w0,
    input  logic [BW-1:0] b0, input logic [DW-1:0] d0,
    input  logic r1, input logic [AW-1:0] a1, input logic w1,
    input  logic [BW-1:0] b1, input logic [DW-1:0] d1,
    input  logic [DW-1:0] rd,
    output int win);
    int rv_port;
    @(negedge clk);
    rst_n = rn;
    p0_req_i = r0; p0_addr_i = a0; p0_we_i = w0; p0_be_i = b0; p0_wdata_i = d0;
    p1_req_i = r1; p1_addr_i = a1; p1_we_i = w1; p1_be_i = b1; p1_wdata_i = d1;
    ram_rdata_i = rd;
    #1;
    if (r0 && r1) begin
`ifdef RAM_PORT_ARB_RR_EN
      win = 1 - last_port;
`else
      win = 1;
`endif
    end else if (r1) win = 1;
    else if (r0) win = 0;
    else win = -1;
    rv_port = (rn && resp_q.size() > 0) ? resp_q[0] : -1;

    checkOutput("p0_gnt", 64'(p0_gnt_o), 64'(win == 0));
    checkOutput("p1_gnt", 64'(p1_gnt_o), 64'(win == 1));
    checkOutput("ram_en", 64'(ram_en_o), 64'(win >= 0));
    checkOutput("ram_addr", 64'(ram_addr_o), (win == 1) ? 64'(a1) : (win == 0) ? 64'(a0) : 64'd0);
    checkOutput("ram_we", 64'(ram_we_o), (win == 1) ? 64'(w1) : (win == 0) ? 64'(w0) : 64'd0);
    checkOutput("ram_be", 64'(ram_be_o), (win == 1) ? 64'(b1) : (win == 0) ? 64'(b0) : 64'd0);
    checkOutput("ram_wdata", 64'(ram_wdata_o), (win == 1) ? 64'(d1) : (win == 0) ? 64'(d0) : 64'd0);
    checkOutput("p0_rvalid", 64'(p0_rvalid_o), 64'(rv_port == 0));
    checkOutput("p1_rvalid", 64'(p1_rvalid_o), 64'(rv_port == 1));
    checkOutput("p0_rdata", 64'(p0_rdata_o), (rv_port == 0) ? 64'(rd) : 64'd0);
    checkOutput("p1_rdata", 64'(p1_rdata_o), (rv_port == 1) ? 64'(rd) : 64'd0);

    resp_q.delete();
    if (!rn) begin
      last_port = 0;
    end else if (win >= 0) begin
      resp_q.push_back(win);
      last_port = win;
    end
  endtask

  task automatic idleCycle(input logic rn, output int win);
    applyStimulus(rn, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, DW'($urandom), win);
  endtask

  logic          h_r0, h_w0, h_r1, h_w1, rn;
  logic [AW-1:0] h_a0, h_a1;
  logic [BW-1:0] h_b0, h_b1;
  logic [DW-1:0] h_d0, h_d1;

  initial begin
    int w;
    rst_n = 1'b0;
    p0_req_i = 1'b0; p0_addr_i = '0; p0_we_i = 1'b0; p0_be_i = '0; p0_wdata_i = '0;
    p1_req_i = 1'b0; p1_addr_i = '0; p1_we_i = 1'b0; p1_be_i = '0; p1_wdata_i = '0;
    ram_rdata_i = '0;

    idleCycle(1'b0, w);
    idleCycle(1'b0, w);

    // Lone p0 read of 0x0040
    applyStimulus(1'b1, 1'b1, 15'h0040, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, '0, '0, 32'h1111_2222, w);
    checkOutput("lone_p0_addr", 64'(ram_addr_o), 64'h40);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 32'hCAFE_0040, w);
    checkOutput("lone_p0_rdata", 64'(p0_rdata_o), 64'hCAFE_0040);

    // Both ports request continuously for 4 cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, AW'(16 * i), 1'b0, 4'hF, '0,
                    1'b1, AW'(16 * i + 4), 1'b0, 4'hF, '0, DW'($urandom), w);
    end
    idleCycle(1'b1, w);

    // p1 partial write
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0,
                  1'b1, 15'h4008, 1'b1, 4'b0011, 32'hDEAD_BEEF, DW'($urandom), w);
    checkOutput("p1_wr_wdata", 64'(ram_wdata_o), 64'hDEAD_BEEF);
    idleCycle(1'b1, w);

    // Grant immediately followed by reset: response is dropped
    applyStimulus(1'b1, 1'b1, 15'h0100, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, '0, '0, DW'($urandom), w);
    idleCycle(1'b0, w);
    checkOutput("rst_drop_p0_rvalid", 64'(p0_rvalid_o), 64'd0);
    idleCycle(1'b1, w);
    checkOutput("post_rst_p0_rvalid", 64'(p0_rvalid_o), 64'd0);

    // Back-to-back reads from 0x0000 then 0x4000
    applyStimulus(1'b1, 1'b1, 15'h0000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, '0, '0, 32'h0, w);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, 15'h4000, 1'b0, 4'hF, '0, 32'hAAAA_0000, w);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 32'hBBBB_4000, w);
    idleCycle(1'b1, w);

    // Random traffic; an ungranted request is held stable until granted
    h_r0 = 1'b0; h_r1 = 1'b0;
    h_a0 = '0; h_a1 = '0; h_w0 = 1'b0; h_w1 = 1'b0;
    h_b0 = '0; h_b1 = '0; h_d0 = '0; h_d1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!h_r0) begin
        h_r0 = ($urandom_range(0, 3) != 0);
        h_a0 = AW'($urandom); h_w0 = 1'($urandom); h_b0 = BW'($urandom); h_d0 = DW'($urandom);
      end
      if (!h_r1) begin
        h_r1 = ($urandom_range(0, 3) != 0);
        h_a1 = AW'($urandom); h_w1 = 1'($urandom); h_b1 = BW'($urandom); h_d1 = DW'($urandom);
      end
      rn = ($urandom_range(0, 39) != 0);
      applyStimulus(rn, h_r0, h_a0, h_w0, h_b0, h_d0,
                    h_r1, h_a1, h_w1, h_b1, h_d1, DW'($urandom), w);
      if (w == 0) h_r0 = 1'b0;
      if (w == 1) h_r1 = 1'b0;
    end
    idleCycle(1'b1, w);
    idleCycle(1'b1, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
